binary_game_core: RTL and testbench

- Parametrised successor to the fixed 4-bit game logic, timer and generator trio.
- Integrates target generation (LFSR), per-level countdown, guess evaluation, level progression and a lives counter in one synchronous controller.
- Sits between the button debouncer / switch inputs and the display driver.
- Adds variable number width, lives, shrinking time per level, and a win/game-over terminal state.

---
 rtl/binary_game_if.sv | 25 ++
 rtl/binary_game_core.sv | 146 ++++++++++++++
 tb/tb_binary_game_core.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/binary_game_if.sv
// Player-side bundle for the binary guessing game core: switch/button inputs
// in, game status out toward the display driver.
interface binary_game_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             guess;
    logic [WIDTH-1:0] switches;
    logic [WIDTH-1:0] target;
    logic [2:0]       state;
    logic [7:0]       level;
    logic [2:0]       lives;
    logic [4:0]       timeleft;
    logic             last_hit;

    modport master (
        output start, guess, switches,
        input  target, state, level, lives, timeleft, last_hit
    );

    modport slave (
        input  start, guess, switches,
        output target, state, level, lives, timeleft, last_hit
    );
endinterface

// File: rtl/binary_game_core.sv
// Binary guessing game controller: LFSR target generation, per-level countdown,
// guess evaluation, level progression and lives, all in one registered FSM.
//
// state  | meaning
// IDLE   | powered up, waiting for start
// ARM    | one cycle: load new target and round time
// PLAY   | countdown running, waiting for a guess
// RESULT | show outcome for HOLD_CYC cycles, then decide
// OVER   | out of lives, outputs frozen until start
// WIN    | matched at MAX_LEVEL, outputs frozen until start
module binary_game_core #(
    parameter int          WIDTH         = 4,
    parameter int          TICKS_PER_SEC = 50000000,
    parameter int          INIT_TIME     = 20,
    parameter int          TIME_STEP     = 2,
    parameter int          MIN_TIME      = 3,
    parameter int          LIVES         = 3,
    parameter int          MAX_LEVEL     = 10,
    parameter int          HOLD_CYC      = 100000000,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    binary_game_if.slave  bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;
    localparam logic [2:0] S_WIN    = 3'd5;

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_SEC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
    localparam logic [7:0]    LEVEL_MAX  = 8'(MAX_LEVEL);

    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_next;
    logic [2:0]       state_q;
    logic [7:0]       level_q;
    logic [2:0]       lives_q;
    logic [4:0]       timeleft_q;
    logic [WIDTH-1:0] target_q;
    logic             last_hit_q;
    logic [PW-1:0]    pre_q;
    logic [HW-1:0]    hold_q;

    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] next_target;
    logic [2:0]       lives_dec;
    logic             pre_wrap;

    // Signed arithmetic so a large level never underflows below MIN_TIME.
    function automatic logic [4:0] round_time(input logic [7:0] lvl);
        int t;
        t = INIT_TIME - (int'(lvl) - 1) * TIME_STEP;
        if (t < MIN_TIME) t = MIN_TIME;
        return 5'(t);
    endfunction

    assign lfsr_next   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign cand        = lfsr_q[WIDTH-1:0];
    assign next_target = (cand == target_q) ? (cand ^ WIDTH'(1)) : cand;
    assign lives_dec   = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
    assign pre_wrap    = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q     <= SEED;
            state_q    <= S_IDLE;
            level_q    <= 8'd0;
            lives_q    <= 3'd0;
            timeleft_q <= 5'd0;
            target_q   <= '0;
            last_hit_q <= 1'b0;
            pre_q      <= '0;
            hold_q     <= '0;
        end else begin
            lfsr_q <= lfsr_next;
            case (state_q)
                S_IDLE, S_OVER, S_WIN: begin
                    if (bus.start) begin
                        level_q <= 8'd1;
                        lives_q <= LIVES_INIT;
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    target_q   <= next_target;
                    timeleft_q <= round_time(level_q);
                    pre_q      <= '0;
                    state_q    <= S_PLAY;
                end
                S_PLAY: begin
                    // A guess on the expiry cycle wins; the tick is dropped.
                    if (bus.guess) begin
                        last_hit_q <= (bus.switches == target_q);
                        if (bus.switches != target_q) lives_q <= lives_dec;
                        hold_q  <= '0;
                        state_q <= S_RESULT;
                    end else if (pre_wrap) begin
                        pre_q <= '0;
                        if (timeleft_q <= 5'd1) begin
                            timeleft_q <= 5'd0;
                            last_hit_q <= 1'b0;
                            lives_q    <= lives_dec;
                            hold_q     <= '0;
                            state_q    <= S_RESULT;
                        end else begin
                            timeleft_q <= timeleft_q - 5'd1;
                        end
                    end else begin
                        pre_q <= pre_q + PW'(1);
                    end
                end
                S_RESULT: begin
                    if (hold_q == HOLD_LAST) begin
                        if (last_hit_q && level_q >= LEVEL_MAX) begin
                            state_q <= S_WIN;
                        end else if (last_hit_q) begin
                            level_q <= level_q + 8'd1;
                            state_q <= S_ARM;
                        end else if (lives_q == 3'd0) begin
                            state_q <= S_OVER;
                        end else begin
                            state_q <= S_ARM;
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.target   = target_q;
    assign bus.state    = state_q;
    assign bus.level    = level_q;
    assign bus.lives    = lives_q;
    assign bus.timeleft = timeleft_q;
    assign bus.last_hit = last_hit_q;
endmodule

// File: tb/tb_binary_game_core.sv
// Randomized bench for binary_game_core against a rule-level reference model,
// with directed passes for level progression, timeout, expiry tie and reset.
module tb_binary_game_core;
    localparam int WIDTH = 4;
    localparam int TPS   = 4;
    localparam int INIT  = 5;
    localparam int STEP  = 1;
    localparam int MINT  = 3;
    localparam int LIV   = 2;
    localparam int MAXL  = 3;
    localparam int HOLD  = 3;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    binary_game_if #(.WIDTH(WIDTH)) bus ();

    binary_game_core #(
        .WIDTH(WIDTH), .TICKS_PER_SEC(TPS), .INIT_TIME(INIT), .TIME_STEP(STEP),
        .MIN_TIME(MINT), .LIVES(LIV), .MAX_LEVEL(MAXL), .HOLD_CYC(HOLD),
        .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: game described in terms of elapsed cycles, not counters
    int m_state, m_level, m_lives, m_tl, m_target, m_hit, m_lfsr;
    int m_t0, m_play_cyc, m_hold_cyc;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int round_secs(input int lvl);
        int t;
        t = INIT - (lvl - 1) * STEP;
        return (t < MINT) ? MINT : t;
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 0; m_lives = 0; m_tl = 0; m_target = 0; m_hit = 0;
        m_lfsr = 16'hACE1; m_t0 = 0; m_play_cyc = 0; m_hold_cyc = 0;
    endtask

    task automatic model_step(input int st, input int gs, input int sw);
        int cand;
        case (m_state)
            0, 4, 5: if (st != 0) begin m_level = 1; m_lives = LIV; m_state = 1; end
            1: begin
                cand = m_lfsr & MASK;
                if (cand == m_target) cand = cand ^ 1;
                m_target = cand;
                m_t0 = round_secs(m_level);
                m_tl = m_t0;
                m_play_cyc = 0;
                m_state = 2;
            end
            2: begin
                if (gs != 0) begin
                    m_hit = (sw == m_target) ? 1 : 0;
                    if (m_hit == 0 && m_lives > 0) m_lives--;
                    m_state = 3; m_hold_cyc = 0;
                end else if (m_play_cyc + 1 == m_t0 * TPS) begin
                    m_hit = 0; m_tl = 0;
                    if (m_lives > 0) m_lives--;
                    m_state = 3; m_hold_cyc = 0;
                end else begin
                    m_play_cyc++;
                    m_tl = m_t0 - m_play_cyc / TPS;
                end
            end
            3: begin
                m_hold_cyc++;
                if (m_hold_cyc == HOLD) begin
                    if (m_hit != 0 && m_level == MAXL) m_state = 5;
                    else if (m_hit != 0) begin m_level++; m_state = 1; end
                    else if (m_lives == 0) m_state = 4;
                    else m_state = 1;
                end
            end
            default: m_state = 0;
        endcase
        m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 16'hB400 : 0);
    endtask

    task automatic compare_all();
        chk_eq("state", int'(bus.state), m_state);
        chk_eq("level", int'(bus.level), m_level);
        chk_eq("lives", int'(bus.lives), m_lives);
        chk_eq("timeleft", int'(bus.timeleft), m_tl);
        chk_eq("target", int'(bus.target), m_target);
        chk_eq("last_hit", int'(bus.last_hit), m_hit);
    endtask

    // called right after a negedge; one full clock, then compare at next negedge
    task automatic tick(input int st, input int gs, input int sw);
        bus.start = st[0];
        bus.guess = gs[0];
        bus.switches = sw[WIDTH-1:0];
        @(posedge clk);
        model_step(st, gs, sw);
        @(negedge clk);
        bus.start = 1'b0;
        bus.guess = 1'b0;
        compare_all();
    endtask

    task automatic run_until(input int s, input int budget);
        int n;
        n = 0;
        while (int'(bus.state) != s && n < budget) begin
            tick(0, 0, 0);
            n++;
        end
        chk_eq("reach_state", int'(bus.state), s);
    endtask

    task automatic hit_now();
        tick(0, 1, m_target);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int prev_target, cyc;
        bus.start = 1'b0;
        bus.guess = 1'b0;
        bus.switches = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // start: IDLE -> ARM -> PLAY
        tick(1, 0, 0);
        chk_eq("arm_state", int'(bus.state), 1);
        tick(0, 0, 0);
        chk_eq("play_level1_time", int'(bus.timeleft), 5);

        // three hits in a row: level 2 (4 s), level 3 (3 s), then WIN
        hit_now();
        chk_eq("hit_flag", int'(bus.last_hit), 1);
        run_until(2, 10);
        chk_eq("level2_time", int'(bus.timeleft), 4);
        hit_now();
        run_until(2, 10);
        chk_eq("level3_time", int'(bus.timeleft), 3);
        hit_now();
        run_until(5, 10);
        tick(0, 1, m_target);
        chk_eq("win_hold", int'(bus.state), 5);
        prev_target = m_target;
        tick(1, 0, 0);
        tick(0, 0, 0);
        chk_eq("restart_lives", int'(bus.lives), 2);
        chk_eq("target_differs", (int'(bus.target) != prev_target) ? 1 : 0, 1);

        // two timeouts at level 1 -> OVER
        cyc = 0;
        while (int'(bus.state) == 2 && cyc < 40) begin tick(0, 0, 0); cyc++; end
        chk_eq("timeout_cycles", cyc, 20);
        chk_eq("timeout_lives", int'(bus.lives), 1);
        run_until(2, 10);
        run_until(4, 40);
        repeat (3) tick(0, 1, 0);
        chk_eq("over_hold", int'(bus.state), 4);

        // hit on the exact expiry cycle beats the timeout
        tick(1, 0, 0);
        tick(0, 0, 0);
        repeat (19) tick(0, 0, 0);
        hit_now();
        chk_eq("tie_hit", int'(bus.last_hit), 1);
        chk_eq("tie_lives", int'(bus.lives), 2);
        chk_eq("tie_time", int'(bus.timeleft), 1);

        // reach level 2 PLAY with 3 s left, then reset asynchronously
        run_until(2, 10);
        repeat (4) tick(0, 0, 0);
        chk_eq("pre_reset_time", int'(bus.timeleft), 3);
        async_reset();
        tick(0, 1, 0);
        chk_eq("post_reset_idle", int'(bus.state), 0);

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            int st, gs, sw;
            if ($urandom_range(0, 799) == 0) begin
                async_reset();
            end else begin
                st = ($urandom_range(0, 24) == 0) ? 1 : 0;
                gs = ($urandom_range(0, 5) == 0) ? 1 : 0;
                sw = ($urandom_range(0, 1) == 0) ? m_target : int'($urandom_range(0, MASK));
                tick(st, gs, sw);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
